// File: rtl/sd_dat_block_sequencer.sv
// rtl/sd_dat_block_sequencer.sv - sequences SDIO read-data blocks from a byte FIFO into the DAT transmitter
//
// Ports:
//   clock, reset_n          : system clock, asynchronous active-low reset
//   start, block_size,
//   block_count, abort      : transfer control from the CMD53 decoder
//   busy, done, aborted,
//   blocks_sent, underrun   : transfer status
//   fifo_rd, fifo_data,
//   fifo_level              : registered-read byte FIFO (data valid the cycle after fifo_rd)
//   stream_*                : DAT transmitter frame/byte handshake
module sd_dat_block_sequencer #(
    parameter int LEVEL_W = 12,
    parameter int COUNT_W = 9
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [11:0]        block_size,
    input  logic [COUNT_W-1:0] block_count,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [COUNT_W-1:0] blocks_sent,
    output logic               underrun,
    output logic               fifo_rd,
    input  logic [7:0]         fifo_data,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic               stream_start_write,
    input  logic               stream_data_req,
    output logic               stream_data_strobe,
    output logic [7:0]         stream_data,
    output logic               stream_data_empty,
    input  logic               stream_read_disabled
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIFO,
        S_SEND,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        len_q, len_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [11:0]        req_cnt_q, req_cnt_d;
    logic               abort_pend_q, abort_pend_d;
    logic               rd_dis_q, rd_dis_d;
    logic               cap_q, cap_d;          // byte capture due this cycle
    logic               cap_ff_q, cap_ff_d;    // captured byte is the underrun filler
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [COUNT_W-1:0] blocks_sent_q, blocks_sent_d;
    logic               underrun_q, underrun_d;
    logic               start_write_q, start_write_d;
    logic               strobe_q, strobe_d;
    logic [7:0]         data_q, data_d;
    logic               empty_q, empty_d;
    logic [11:0]        req_next;
    logic [COUNT_W-1:0] blocks_inc;

    assign busy               = busy_q;
    assign done               = done_q;
    assign aborted            = aborted_q;
    assign blocks_sent        = blocks_sent_q;
    assign underrun           = underrun_q;
    assign stream_start_write = start_write_q;
    assign stream_data_strobe = strobe_q;
    assign stream_data        = data_q;
    assign stream_data_empty  = empty_q;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        req_cnt_d     = req_cnt_q;
        abort_pend_d  = abort_pend_q;
        rd_dis_d      = stream_read_disabled;
        cap_d         = 1'b0;
        cap_ff_d      = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        aborted_d     = aborted_q;
        blocks_sent_d = blocks_sent_q;
        underrun_d    = underrun_q;
        start_write_d = 1'b0;
        strobe_d      = 1'b0;
        data_d        = data_q;
        empty_d       = empty_q;
        fifo_rd       = 1'b0;
        req_next      = req_cnt_q + 12'd1;
        blocks_inc    = blocks_sent_q + COUNT_W'(1);

        // Byte popped last cycle is on fifo_data now; strobe it next cycle.
        if (cap_q) begin
            data_d   = cap_ff_q ? 8'hFF : fifo_data;
            strobe_d = 1'b1;
        end

        if (busy_q && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d         = (block_size == 12'd0) ? 12'd512 : block_size;
                    count_d       = block_count;
                    blocks_sent_d = '0;
                    underrun_d    = 1'b0;
                    aborted_d     = 1'b0;
                    abort_pend_d  = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = S_WAIT_FIFO;
                end
            end
            S_WAIT_FIFO: begin
                if (abort_pend_q) begin
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (fifo_level >= LEVEL_W'(len_q)) begin
                    // Whole block present up front, so the frame never stalls.
                    start_write_d = 1'b1;
                    req_cnt_d     = 12'd0;
                    empty_d       = 1'b0;
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                // Counting saturates at len+1: later requests are ignored.
                if (stream_data_req && (req_cnt_q <= len_q)) begin
                    req_cnt_d = req_next;
                    if (req_next <= len_q) begin
                        cap_d = 1'b1;
                        if (fifo_level == '0) begin
                            underrun_d = 1'b1;
                            cap_ff_d   = 1'b1;
                        end else begin
                            fifo_rd = 1'b1;
                        end
                    end else begin
                        empty_d = 1'b1;
                    end
                end
                if (stream_read_disabled) begin
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                // Block is finished when the transmitter's busy frame ends.
                if (rd_dis_q && !stream_read_disabled) begin
                    blocks_sent_d = blocks_inc;
                    if ((count_q != '0) && (blocks_inc == count_q)) begin
                        done_d    = 1'b1;
                        aborted_d = abort_pend_q | abort;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_WAIT_FIFO;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            count_q       <= '0;
            req_cnt_q     <= '0;
            abort_pend_q  <= 1'b0;
            rd_dis_q      <= 1'b0;
            cap_q         <= 1'b0;
            cap_ff_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            blocks_sent_q <= '0;
            underrun_q    <= 1'b0;
            start_write_q <= 1'b0;
            strobe_q      <= 1'b0;
            data_q        <= '0;
            empty_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            req_cnt_q     <= req_cnt_d;
            abort_pend_q  <= abort_pend_d;
            rd_dis_q      <= rd_dis_d;
            cap_q         <= cap_d;
            cap_ff_q      <= cap_ff_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            blocks_sent_q <= blocks_sent_d;
            underrun_q    <= underrun_d;
            start_write_q <= start_write_d;
            strobe_q      <= strobe_d;
            data_q        <= data_d;
            empty_q       <= empty_d;
        end
    end

endmodule

// File: tb/tb_sd_dat_block_sequencer.sv
// tb/tb_sd_dat_block_sequencer.sv - randomized bench with FIFO, transmitter and block-level reference model
module tb_sd_dat_block_sequencer;

    localparam int LEVEL_W = 12;
    localparam int COUNT_W = 9;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [11:0]        block_size = '0;
    logic [COUNT_W-1:0] block_count = '0;
    logic               abort = 1'b0;
    logic               busy, done, aborted, underrun, fifo_rd;
    logic [COUNT_W-1:0] blocks_sent;
    logic [7:0]         fifo_data = '0;
    logic [LEVEL_W-1:0] fifo_level = '0;
    logic               stream_start_write, stream_data_strobe, stream_data_empty;
    logic [7:0]         stream_data;
    logic               stream_data_req = 1'b0;
    logic               stream_read_disabled = 1'b0;

    sd_dat_block_sequencer #(.LEVEL_W(LEVEL_W), .COUNT_W(COUNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .block_size(block_size),
        .block_count(block_count), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .blocks_sent(blocks_sent), .underrun(underrun),
        .fifo_rd(fifo_rd), .fifo_data(fifo_data), .fifo_level(fifo_level),
        .stream_start_write(stream_start_write), .stream_data_req(stream_data_req),
        .stream_data_strobe(stream_data_strobe), .stream_data(stream_data),
        .stream_data_empty(stream_data_empty), .stream_read_disabled(stream_read_disabled)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Environment / reference state
    logic [7:0] fq[$];          // FIFO contents in push order
    logic [7:0] exp_bytes[$];   // bytes the current block must still strobe
    int  cyc = 0, cur_len = 1, blk_reqs = 0, blk_strobes = 0, starts = 0;
    int  last_req_cyc = 0, tx_st = 0, tx_wait = 0, lvl_ok_cyc = -1, first_sw_cyc = -1;
    int  prev_level = 0;
    bit  env_on = 1'b1, drain_req = 1'b0, pop_pend = 1'b0, empty_prev = 1'b0;
    bit  next_req = 1'b0, rd_dis_next = 1'b0;

    initial begin : env
        forever begin
            @(negedge clock);
            cyc++;
            pop_pend = 1'b0;
            if (env_on) begin
                if (stream_data_req) begin
                    blk_reqs++;
                    last_req_cyc = cyc;
                    if (blk_reqs <= cur_len && fifo_level != 0) begin
                        expect_eq("fifo_rd", fifo_rd, 1);
                        exp_bytes.push_back(fq[0]);
                    end else begin
                        expect_eq("fifo_rd_gated", fifo_rd, 0);
                        if (blk_reqs <= cur_len) exp_bytes.push_back(8'hFF);
                    end
                end else if (fifo_rd) begin
                    expect_eq("fifo_rd_spurious", fifo_rd, 0);
                end
                pop_pend = fifo_rd;
                if (stream_data_strobe) begin
                    expect_eq("strobe_latency", cyc - last_req_cyc, 2);
                    expect_eq("strobe_expected", exp_bytes.size() > 0, 1);
                    if (exp_bytes.size() > 0) expect_eq("strobe_data", stream_data, exp_bytes.pop_front());
                    blk_strobes++;
                end
                if (stream_start_write) begin
                    expect_eq("sw_level_ok", prev_level >= cur_len, 1);
                    expect_eq("sw_blocks_sent", blocks_sent, starts);
                    expect_eq("sw_tx_idle", tx_st, 0);
                    starts++;
                    if (first_sw_cyc < 0) first_sw_cyc = cyc;
                    blk_reqs = 0;
                    blk_strobes = 0;
                    exp_bytes.delete();
                    tx_st = 1;
                    tx_wait = $urandom_range(0, 2);
                end
                if (stream_data_empty && !empty_prev) begin
                    expect_eq("empty_req_count", blk_reqs, cur_len + 1);
                    expect_eq("empty_latency", cyc - last_req_cyc, 1);
                end
                if (lvl_ok_cyc < 0 && fifo_level >= cur_len) lvl_ok_cyc = cyc;
                empty_prev = stream_data_empty;
                prev_level = int'(fifo_level);
            end
            // Transmitter: request with gaps >= 3 cycles until empty, then a busy frame.
            next_req = 1'b0;
            case (tx_st)
                1: begin
                    if (tx_wait > 0) tx_wait--;
                    else if (stream_data_empty && blk_reqs > 0) begin
                        if (env_on) expect_eq("block_strobes", blk_strobes, cur_len);
                        tx_st = 2;
                        rd_dis_next = 1'b1;
                        tx_wait = $urandom_range(0, 3);
                    end else begin
                        next_req = 1'b1;
                        tx_wait = $urandom_range(2, 4);
                    end
                end
                2: begin
                    if (tx_wait > 0) tx_wait--;
                    else begin
                        rd_dis_next = 1'b0;
                        tx_st = 0;
                    end
                end
                default: ;
            endcase
            @(posedge clock);
            #1;
            if (pop_pend && fq.size() > 0) fifo_data = fq.pop_front();
            if (drain_req) begin
                fq.delete();
                drain_req = 1'b0;
            end
            fifo_level = LEVEL_W'(fq.size());
            stream_data_req = next_req;
            stream_read_disabled = rd_dis_next;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
    endtask

    task automatic flush();
        drain_req = 1'b1;
        repeat (2) tick();
    endtask

    task automatic run_xfer(input int bs, input int bc, input int exp_blocks, input bit exp_ab,
                            input int abort_blk, input bit refill, input int drain_at, input int late_push);
        int pushed;
        bit ab_done, dr_done, junk_done, got_done;
        pushed = 1; ab_done = 0; dr_done = 0; junk_done = 0; got_done = 0;
        cur_len = (bs == 0) ? 512 : bs;
        starts = 0; first_sw_cyc = -1; lvl_ok_cyc = -1;
        exp_bytes.delete();
        tick();
        block_size = 12'(bs);
        block_count = COUNT_W'(bc);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clock);
        expect_eq("busy_after_start", busy, 1);
        expect_eq("underrun_cleared", underrun, 0);
        for (int k = 0; k < 20000 && !got_done; k++) begin
            if (done) got_done = 1;
            else begin
                if (late_push > 0 && k == 30) push_bytes(late_push);
                if (refill && starts == pushed && pushed < exp_blocks) begin
                    push_bytes(cur_len);
                    pushed++;
                end
                if (refill && !junk_done && starts == 1 && blk_strobes == 1) begin
                    tick();
                    block_size = 12'd5;
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    junk_done = 1;
                end
                if (abort_blk > 0 && !ab_done && starts == abort_blk && blk_strobes >= cur_len / 2) begin
                    tick();
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    ab_done = 1;
                end
                if (drain_at > 0 && !dr_done && blk_strobes >= drain_at) begin
                    drain_req = 1'b1;
                    dr_done = 1;
                end
                @(negedge clock);
            end
        end
        expect_eq("done_seen", got_done, 1);
        if (got_done) begin
            expect_eq("blocks_sent", blocks_sent, exp_blocks);
            expect_eq("aborted", aborted, exp_ab);
            expect_eq("frames", starts, exp_blocks);
            @(negedge clock);
            expect_eq("done_pulse", done, 0);
            expect_eq("busy_end", busy, 0);
        end
    endtask

    initial begin : main
        int bs, bc;
        bit mid_ok;
        repeat (3) @(posedge clock);
        @(negedge clock);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);
        expect_eq("rst_aborted", aborted, 0);
        expect_eq("rst_blocks_sent", blocks_sent, 0);
        expect_eq("rst_underrun", underrun, 0);
        expect_eq("rst_fifo_rd", fifo_rd, 0);
        expect_eq("rst_start_write", stream_start_write, 0);
        expect_eq("rst_strobe", stream_data_strobe, 0);
        expect_eq("rst_data", stream_data, 0);
        expect_eq("rst_empty", stream_data_empty, 0);
        tick();
        reset_n = 1'b1;

        // Single 4-byte block with bytes 01..04
        flush();
        for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
        run_xfer(4, 1, 1, 0, 0, 0, 0, 0);

        // Three 512-byte blocks (block_size 0), refilled a block at a time
        flush();
        push_bytes(512);
        run_xfer(0, 3, 3, 0, 0, 1, 0, 0);

        // One-byte block
        flush();
        push_bytes(1);
        run_xfer(1, 1, 1, 0, 0, 0, 0, 0);

        // Launch waits for the level to reach block_size
        flush();
        push_bytes(100);
        run_xfer(128, 1, 1, 0, 0, 0, 0, 28);
        expect_eq("sw_after_level", first_sw_cyc - lvl_ok_cyc, 1);

        // Unlimited count, abort in the middle of block 5
        flush();
        push_bytes(40);
        run_xfer(6, 0, 5, 1, 5, 0, 0, 0);

        // External drain mid-block produces an underrun
        flush();
        push_bytes(16);
        run_xfer(16, 1, 1, 0, 0, 0, 4, 0);
        expect_eq("underrun_set", underrun, 1);

        // Random sizes and counts
        repeat (4) begin
            bs = $urandom_range(1, 40);
            bc = $urandom_range(1, 3);
            flush();
            push_bytes(bs * bc);
            run_xfer(bs, bc, bc, 0, 0, 0, 0, 0);
        end

        // Reset in the middle of a block
        flush();
        push_bytes(8);
        cur_len = 8;
        starts = 0;
        tick();
        block_size = 12'd8;
        block_count = COUNT_W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        mid_ok = 0;
        for (int k = 0; k < 400 && !mid_ok; k++) begin
            @(negedge clock);
            if (blk_strobes >= 2 && starts == 1) mid_ok = 1;
        end
        expect_eq("mid_block_reached", mid_ok, 1);
        env_on = 1'b0;
        reset_n = 1'b0;
        #1;
        expect_eq("mid_rst_busy", busy, 0);
        expect_eq("mid_rst_empty", stream_data_empty, 0);
        expect_eq("mid_rst_data", stream_data, 0);
        expect_eq("mid_rst_blocks", blocks_sent, 0);
        expect_eq("mid_rst_fifo_rd", fifo_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
